// File: rtl/wb_buf.sv
// Writeback buffer: DEPTH-entry FIFO between MEM and the register-file write port.
// Define WB_FWD_EN to build the forwarding lookup across buffered entries.

`ifndef DEST_SRC_NONE
`define DEST_SRC_NONE 0
`endif

module wb_buf #(
    parameter int ADDR_W     = 32,
    parameter int INSTR_W    = 32,
    parameter int WORD_W     = 32,
    parameter int REG_IDX_W  = 5,
    parameter int DEST_SRC_W = 2,
    parameter int DEPTH      = 4,
    parameter int CNT_W      = 32
) (
    input  logic                       clk,
    input  logic                       clr_n,
    input  logic                       flush,
    input  logic                       i_valid,
    output logic                       o_ready,
    input  logic [ADDR_W-1:0]          i_pc,
    input  logic [INSTR_W-1:0]         i_instr,
    input  logic [DEST_SRC_W-1:0]      i_dest_src,
    input  logic [REG_IDX_W-1:0]       i_dest_reg,
    input  logic [WORD_W-1:0]          i_dest_data,
    input  logic                       i_rf_ready,
    output logic                       o_valid,
    output logic [ADDR_W-1:0]          o_pc,
    output logic [INSTR_W-1:0]         o_instr,
    output logic                       o_dest_en,
    output logic [REG_IDX_W-1:0]       o_dest_reg,
    output logic [WORD_W-1:0]          o_dest_data,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic [CNT_W-1:0]           o_retire_cnt,
    input  logic [REG_IDX_W-1:0]       i_fwd_reg,
    output logic                       o_fwd_hit,
    output logic [WORD_W-1:0]          o_fwd_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = DEPTH[PTR_W:0];
    localparam logic [DEST_SRC_W-1:0] DEST_NONE = DEST_SRC_W'(`DEST_SRC_NONE);

    logic [ADDR_W-1:0]    pcMem   [DEPTH];
    logic [INSTR_W-1:0]   instrMem[DEPTH];
    logic [REG_IDX_W-1:0] regMem  [DEPTH];
    logic [WORD_W-1:0]    dataMem [DEPTH];
    logic                 enMem   [DEPTH];

    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [CNT_W-1:0] retire_q, retire_d;

    logic headValid;
    logic push;
    logic pop;
    logic inDestEn;

    assign headValid = (count_q != '0);
    assign o_ready   = (count_q != FULL_COUNT);
    assign push      = i_valid && o_ready && !flush;
    assign pop       = headValid && i_rf_ready;
    assign inDestEn  = (i_dest_src != DEST_NONE) && (i_dest_reg != '0);

    // A pop in the flush cycle still retires; everything else is cleared.
    always_comb begin
        wrPtr_d  = wrPtr_q;
        rdPtr_d  = rdPtr_q;
        count_d  = count_q;
        retire_d = pop ? retire_q + CNT_W'(1) : retire_q;
        if (flush) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else begin
            if (push) wrPtr_d = wrPtr_q + PTR_W'(1);
            if (pop)  rdPtr_d = rdPtr_q + PTR_W'(1);
            if (push && !pop)      count_d = count_q + (PTR_W+1)'(1);
            else if (!push && pop) count_d = count_q - (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            wrPtr_q  <= '0;
            rdPtr_q  <= '0;
            count_q  <= '0;
            retire_q <= '0;
        end else begin
            wrPtr_q  <= wrPtr_d;
            rdPtr_q  <= rdPtr_d;
            count_q  <= count_d;
            retire_q <= retire_d;
        end
    end

    // Entry storage needs no reset: every read is qualified by occupancy.
    always_ff @(posedge clk) begin
        if (push) begin
            pcMem[wrPtr_q]    <= i_pc;
            instrMem[wrPtr_q] <= i_instr;
            regMem[wrPtr_q]   <= i_dest_reg;
            dataMem[wrPtr_q]  <= i_dest_data;
            enMem[wrPtr_q]    <= inDestEn;
        end
    end

    assign o_valid      = headValid;
    assign o_pc         = headValid ? pcMem[rdPtr_q]    : '0;
    assign o_instr      = headValid ? instrMem[rdPtr_q] : '0;
    assign o_dest_reg   = headValid ? regMem[rdPtr_q]   : '0;
    assign o_dest_data  = headValid ? dataMem[rdPtr_q]  : '0;
    assign o_dest_en    = headValid && enMem[rdPtr_q];
    assign o_count      = count_q;
    assign o_retire_cnt = retire_q;

`ifdef WB_FWD_EN
    logic [PTR_W-1:0]  fwdIdx;
    logic              fwdHit;
    logic [WORD_W-1:0] fwdData;

    // Walk oldest to youngest so the youngest match overwrites earlier ones.
    always_comb begin
        fwdIdx  = rdPtr_q;
        fwdHit  = 1'b0;
        fwdData = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwdIdx = rdPtr_q + PTR_W'(i);
            if (((PTR_W+1)'(i) < count_q) && enMem[fwdIdx] && (regMem[fwdIdx] == i_fwd_reg)) begin
                fwdHit  = 1'b1;
                fwdData = dataMem[fwdIdx];
            end
        end
    end

    assign o_fwd_hit  = fwdHit;
    assign o_fwd_data = fwdData;
`else
    assign o_fwd_hit  = 1'b0 & (|i_fwd_reg);
    assign o_fwd_data = '0;
`endif

endmodule

// File: tb/tb_wb_buf.sv
// Self-checking bench for wb_buf: queue-based reference model compared every
// cycle, plus directed literal expectations. Honours WB_FWD_EN like the RTL.

`ifndef DEST_SRC_NONE
`define DEST_SRC_NONE 0
`endif

module tb_wb_buf;

   localparam int DEPTH = 4;
   localparam logic [1:0] SRC_NONE = 2'(`DEST_SRC_NONE);
   localparam logic [1:0] SRC_ALU  = (SRC_NONE == 2'd1) ? 2'd2 : 2'd1;

   logic        clk;
   logic        clr_n;
   logic        flush;
   logic        i_valid;
   logic        o_ready;
   logic [31:0] i_pc;
   logic [31:0] i_instr;
   logic [1:0]  i_dest_src;
   logic [4:0]  i_dest_reg;
   logic [31:0] i_dest_data;
   logic        i_rf_ready;
   logic        o_valid;
   logic [31:0] o_pc;
   logic [31:0] o_instr;
   logic        o_dest_en;
   logic [4:0]  o_dest_reg;
   logic [31:0] o_dest_data;
   logic [2:0]  o_count;
   logic [31:0] o_retire_cnt;
   logic [4:0]  i_fwd_reg;
   logic        o_fwd_hit;
   logic [31:0] o_fwd_data;

   int compared = 0;
   int mismatched = 0;

   wb_buf #(.DEPTH(DEPTH)) dut (
      .clk(clk), .clr_n(clr_n), .flush(flush),
      .i_valid(i_valid), .o_ready(o_ready),
      .i_pc(i_pc), .i_instr(i_instr),
      .i_dest_src(i_dest_src), .i_dest_reg(i_dest_reg), .i_dest_data(i_dest_data),
      .i_rf_ready(i_rf_ready),
      .o_valid(o_valid), .o_pc(o_pc), .o_instr(o_instr),
      .o_dest_en(o_dest_en), .o_dest_reg(o_dest_reg), .o_dest_data(o_dest_data),
      .o_count(o_count), .o_retire_cnt(o_retire_cnt),
      .i_fwd_reg(i_fwd_reg), .o_fwd_hit(o_fwd_hit), .o_fwd_data(o_fwd_data)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [1:0]  src;
      logic [4:0]  rg;
      logic [31:0] data;
   } entry_t;

   entry_t      modelQ[$];
   int unsigned modelRetire = 0;

   function automatic logic writesRf(entry_t e);
      return (e.src != SRC_NONE) && (e.rg != 5'd0);
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Reference model: a plain queue updated by the handshake rules at each edge.
   always @(posedge clk or negedge clr_n) begin
      entry_t e;
      logic   doPop;
      logic   doPush;
      if (!clr_n) begin
         modelQ.delete();
         modelRetire = 0;
      end else begin
         doPop  = (modelQ.size() > 0) && i_rf_ready;
         doPush = i_valid && (modelQ.size() < DEPTH);
         e.pc = i_pc; e.instr = i_instr; e.src = i_dest_src; e.rg = i_dest_reg; e.data = i_dest_data;
         if (doPop) modelRetire++;
         if (flush) begin
            modelQ.delete();
         end else begin
            if (doPop)  void'(modelQ.pop_front());
            if (doPush) modelQ.push_back(e);
         end
      end
   end

   // Every falling edge out of reset, all outputs must match the model.
   logic        expHit;
   logic [31:0] expFwd;
   always @(negedge clk) begin
      if (clr_n) begin
         expHit = 1'b0;
         expFwd = 32'd0;
`ifdef WB_FWD_EN
         for (int k = modelQ.size() - 1; k >= 0; k--) begin
            if (!expHit && writesRf(modelQ[k]) && (modelQ[k].rg == i_fwd_reg)) begin
               expHit = 1'b1;
               expFwd = modelQ[k].data;
            end
         end
`endif
         checkOutput("o_count", 64'(o_count), 64'(modelQ.size()));
         checkOutput("o_ready", 64'(o_ready), 64'(modelQ.size() != DEPTH));
         checkOutput("o_valid", 64'(o_valid), 64'(modelQ.size() != 0));
         checkOutput("o_retire_cnt", 64'(o_retire_cnt), 64'(modelRetire));
         checkOutput("o_fwd_hit", 64'(o_fwd_hit), 64'(expHit));
         checkOutput("o_fwd_data", 64'(o_fwd_data), 64'(expFwd));
         if (modelQ.size() != 0) begin
            checkOutput("o_pc", 64'(o_pc), 64'(modelQ[0].pc));
            checkOutput("o_instr", 64'(o_instr), 64'(modelQ[0].instr));
            checkOutput("o_dest_reg", 64'(o_dest_reg), 64'(modelQ[0].rg));
            checkOutput("o_dest_data", 64'(o_dest_data), 64'(modelQ[0].data));
            checkOutput("o_dest_en", 64'(o_dest_en), 64'(writesRf(modelQ[0])));
         end else begin
            checkOutput("o_pc_empty", 64'(o_pc), 64'd0);
            checkOutput("o_instr_empty", 64'(o_instr), 64'd0);
            checkOutput("o_dest_reg_empty", 64'(o_dest_reg), 64'd0);
            checkOutput("o_dest_data_empty", 64'(o_dest_data), 64'd0);
            checkOutput("o_dest_en_empty", 64'(o_dest_en), 64'd0);
         end
      end
   end

   // Drive one cycle of inputs, let one rising edge pass, return 2 ns after it.
   task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [4:0] rg,
                                input logic [1:0] src, input logic [31:0] data,
                                input logic rf, input logic fl, input logic [4:0] fr);
      i_valid     = v;
      i_pc        = pc;
      i_instr     = {pc[15:0], 16'h0013};
      i_dest_reg  = rg;
      i_dest_src  = src;
      i_dest_data = data;
      i_rf_ready  = rf;
      flush       = fl;
      i_fwd_reg   = fr;
      @(posedge clk);
      #2;
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_valid"}, 64'(o_valid), 64'd0);
      checkOutput({tag, "_ready"}, 64'(o_ready), 64'd1);
      checkOutput({tag, "_count"}, 64'(o_count), 64'd0);
      checkOutput({tag, "_retire"}, 64'(o_retire_cnt), 64'd0);
      checkOutput({tag, "_pc"}, 64'(o_pc), 64'd0);
      checkOutput({tag, "_data"}, 64'(o_dest_data), 64'd0);
      checkOutput({tag, "_dest_en"}, 64'(o_dest_en), 64'd0);
      checkOutput({tag, "_fwd_hit"}, 64'(o_fwd_hit), 64'd0);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      clr_n = 1'b0; flush = 1'b0; i_valid = 1'b0; i_pc = '0; i_instr = '0;
      i_dest_src = '0; i_dest_reg = '0; i_dest_data = '0; i_rf_ready = 1'b0; i_fwd_reg = '0;
      #1;
      checkResetOutputs("reset");
      #11 clr_n = 1'b1;
      @(posedge clk);
      #2;

      // Single entry held with register file stalled.
      applyStimulus(1, 32'h100, 5'd3, SRC_ALU, 32'hAA, 0, 0, 5'd0);
      checkOutput("first_valid", 64'(o_valid), 64'd1);
      checkOutput("first_dest_en", 64'(o_dest_en), 64'd1);
      checkOutput("first_data", 64'(o_dest_data), 64'hAA);
      checkOutput("first_count", 64'(o_count), 64'd1);
      for (int i = 0; i < 5; i++) applyStimulus(0, 32'h0, 5'd0, SRC_NONE, 32'h0, 0, 0, 5'd3);
      checkOutput("hold_pc", 64'(o_pc), 64'h100);
      applyStimulus(0, 32'h0, 5'd0, SRC_NONE, 32'h0, 1, 0, 5'd0);
      checkOutput("first_popped_retire", 64'(o_retire_cnt), 64'd1);

      // Fill past capacity; fifth push must be refused.
      applyStimulus(1, 32'h200, 5'd5, SRC_ALU,  32'h11, 0, 0, 5'd0);
      applyStimulus(1, 32'h204, 5'd5, SRC_ALU,  32'h22, 0, 0, 5'd0);
      applyStimulus(1, 32'h208, 5'd0, SRC_ALU,  32'h33, 0, 0, 5'd0);
      applyStimulus(1, 32'h20C, 5'd7, SRC_NONE, 32'h44, 0, 0, 5'd0);
      checkOutput("full_ready", 64'(o_ready), 64'd0);
      checkOutput("full_count", 64'(o_count), 64'd4);
      applyStimulus(1, 32'h210, 5'd9, SRC_ALU,  32'h55, 0, 0, 5'd5);
      checkOutput("overflow_count", 64'(o_count), 64'd4);
      checkOutput("overflow_head", 64'(o_pc), 64'h200);
`ifdef WB_FWD_EN
      checkOutput("fwd_youngest_hit", 64'(o_fwd_hit), 64'd1);
      checkOutput("fwd_youngest_data", 64'(o_fwd_data), 64'h22);
`else
      checkOutput("fwd_disabled_hit", 64'(o_fwd_hit), 64'd0);
`endif
      applyStimulus(0, 32'h0, 5'd0, SRC_NONE, 32'h0, 0, 0, 5'd0);
      checkOutput("fwd_x0_hit", 64'(o_fwd_hit), 64'd0);
      applyStimulus(0, 32'h0, 5'd0, SRC_NONE, 32'h0, 1, 0, 5'd7);
      applyStimulus(0, 32'h0, 5'd0, SRC_NONE, 32'h0, 1, 0, 5'd5);
      checkOutput("x0_head_valid", 64'(o_valid), 64'd1);
      checkOutput("x0_head_dest_en", 64'(o_dest_en), 64'd0);
      applyStimulus(0, 32'h0, 5'd0, SRC_NONE, 32'h0, 1, 0, 5'd0);
      checkOutput("none_head_pc", 64'(o_pc), 64'h20C);
      checkOutput("none_head_dest_en", 64'(o_dest_en), 64'd0);
      applyStimulus(0, 32'h0, 5'd0, SRC_NONE, 32'h0, 1, 0, 5'd0);
      checkOutput("drained_retire", 64'(o_retire_cnt), 64'd5);
      checkOutput("drained_valid", 64'(o_valid), 64'd0);

      // Flush with a simultaneous push and pop.
      applyStimulus(1, 32'h300, 5'd1, SRC_ALU, 32'h1, 0, 0, 5'd0);
      applyStimulus(1, 32'h304, 5'd2, SRC_ALU, 32'h2, 0, 0, 5'd0);
      applyStimulus(1, 32'h308, 5'd3, SRC_ALU, 32'h3, 0, 0, 5'd2);
      checkOutput("preflush_count", 64'(o_count), 64'd3);
      applyStimulus(1, 32'h400, 5'd4, SRC_ALU, 32'h4, 1, 1, 5'd4);
      checkOutput("flush_count", 64'(o_count), 64'd0);
      checkOutput("flush_retire", 64'(o_retire_cnt), 64'd6);
      checkOutput("flush_valid", 64'(o_valid), 64'd0);
      applyStimulus(0, 32'h0, 5'd0, SRC_NONE, 32'h0, 1, 0, 5'd4);

      // Push and pop in the same cycle when not full.
      applyStimulus(1, 32'h500, 5'd6, SRC_ALU, 32'h66, 0, 0, 5'd6);
      applyStimulus(1, 32'h504, 5'd6, SRC_ALU, 32'h77, 1, 0, 5'd6);
      checkOutput("pushpop_count", 64'(o_count), 64'd1);
      checkOutput("pushpop_pc", 64'(o_pc), 64'h504);
      checkOutput("pushpop_retire", 64'(o_retire_cnt), 64'd7);

      // Asynchronous reset between edges, then immediate reuse.
      applyStimulus(1, 32'h600, 5'd8, SRC_ALU, 32'h88, 0, 0, 5'd8);
      i_valid = 1'b0;
      #1 clr_n = 1'b0;
      #1;
      checkResetOutputs("midreset");
      @(negedge clk);
      #1 clr_n = 1'b1;
      applyStimulus(1, 32'h700, 5'd10, SRC_ALU, 32'h99, 0, 0, 5'd10);
      checkOutput("post_reset_count", 64'(o_count), 64'd1);
      checkOutput("post_reset_pc", 64'(o_pc), 64'h700);
      checkOutput("post_reset_retire", 64'(o_retire_cnt), 64'd0);
      for (int i = 0; i < 3; i++) applyStimulus(0, 32'h0, 5'd0, SRC_NONE, 32'h0, 1, 0, 5'd10);
      checkOutput("final_retire", 64'(o_retire_cnt), 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
